// File: rtl/key_matrix_scanner.sv
// Row-scanning key matrix reader: drives one row low at a time, debounces each key
// over whole scans, and queues press events behind a valid/ack handshake.
module key_matrix_scanner #(
    parameter  int ROWS      = 4,
    parameter  int COLS      = 4,
    parameter  int DWELL     = 4,
    parameter  int DEB_SCANS = 3,
    localparam int N         = ROWS * COLS,
    localparam int CODE_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [COLS-1:0]   colIn,
    output logic [ROWS-1:0]   rowOut,
    output logic [N-1:0]      held,
    output logic [N-1:0]      press,
    output logic              evValid,
    output logic [CODE_W-1:0] evCode,
    input  logic              evAck
);

    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CNT_W = (DEB_SCANS > 1) ? $clog2(DEB_SCANS + 1) : 1;

    localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);
    localparam logic [DW-1:0]    D_LAST   = DW'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_SCANS - 1);

    logic [RW-1:0]    r;
    logic [DW-1:0]    d;
    logic             sample;
    logic [COLS-1:0]  sync1, sync2, col_sync;
    logic [N-1:0]     raw;
    logic             eval;
    logic [RW-1:0]    samp_row;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];
    logic [N-1:0]     held_next;
    logic [N-1:0]     held_prev;
    logic [N-1:0]     rise;
    logic [N-1:0]     pending;
    logic [N-1:0]     ack_mask;

    assign sample   = (d == D_LAST);
    assign col_sync = ~sync2;
    assign rise     = held & ~held_prev;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r <= '0;
            d <= '0;
        end else if (sample) begin
            d <= '0;
            r <= (r == ROW_LAST) ? '0 : r + 1'b1;
        end else begin
            d <= d + 1'b1;
        end
    end

    always_comb begin
        rowOut    = '1;
        rowOut[r] = 1'b0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1    <= '0;
            sync2    <= '0;
            raw      <= '0;
            eval     <= 1'b0;
            samp_row <= '0;
        end else begin
            sync1 <= colIn;
            sync2 <= sync1;
            eval  <= sample;
            if (sample) begin
                samp_row <= r;
                for (int unsigned rr = 0; rr < ROWS; rr++) begin
                    if (r == RW'(rr)) raw[rr*COLS +: COLS] <= col_sync;
                end
            end
        end
    end

    // Debounce runs the cycle after the sample, on the freshly captured raw row.
    always_comb begin
        held_next = held;
        cnt_next  = cnt;
        if (eval) begin
            for (int unsigned rr = 0; rr < ROWS; rr++) begin
                for (int unsigned cc = 0; cc < COLS; cc++) begin
                    if (samp_row == RW'(rr)) begin
                        if (raw[rr*COLS+cc] == held[rr*COLS+cc]) begin
                            cnt_next[rr*COLS+cc] = '0;
                        end else if (cnt[rr*COLS+cc] == CNT_LAST) begin
                            held_next[rr*COLS+cc] = ~held[rr*COLS+cc];
                            cnt_next[rr*COLS+cc]  = '0;
                        end else begin
                            cnt_next[rr*COLS+cc] = cnt[rr*COLS+cc] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            held      <= '0;
            held_prev <= '0;
            for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            held      <= held_next;
            held_prev <= held;
            cnt       <= cnt_next;
        end
    end

    always_comb begin
        evCode = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (pending[i-1]) evCode = CODE_W'(i - 1);
        end
    end

    assign evValid = |pending;

    always_comb begin
        ack_mask = '0;
        if (evAck && evValid) ack_mask[evCode] = 1'b1;
    end

    // A new press on the same edge as its ack-clear wins and stays pending.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            press   <= '0;
            pending <= '0;
        end else begin
            press   <= rise;
            pending <= (pending & ~ack_mask) | rise;
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Randomized bench for key_matrix_scanner: a physical matrix model drives colIn and a
// cycle-indexed behavioural model predicts every output after each clock edge.
module tb_key_matrix_scanner;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int DWELL     = 4;
    localparam int DEB_SCANS = 3;
    localparam int N         = ROWS * COLS;
    localparam int PERIOD    = ROWS * DWELL;

    logic           Clock = 1'b0;
    logic           Reset = 1'b1;
    logic [COLS-1:0] colIn;
    logic [ROWS-1:0] rowOut;
    logic [N-1:0]   held;
    logic [N-1:0]   press;
    logic           evValid;
    logic [3:0]     evCode;
    logic           evAck = 1'b0;
    logic [N-1:0]   keys  = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    int          n;
    logic [N-1:0] hist[$];
    logic [N-1:0] m_held, m_held_prev, m_press, m_pending;
    int          m_cnt[N];

    key_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .DEB_SCANS(DEB_SCANS)
    ) dut (
        .Clock(Clock), .Reset(Reset), .colIn(colIn), .rowOut(rowOut),
        .held(held), .press(press), .evValid(evValid), .evCode(evCode), .evAck(evAck)
    );

    always #5 Clock = ~Clock;

    // closed key on a driven-low row pulls its column low
    always_comb begin
        colIn = '1;
        for (int rr = 0; rr < ROWS; rr++)
            for (int cc = 0; cc < COLS; cc++)
                if (!rowOut[rr] && keys[rr*COLS+cc]) colIn[cc] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        hist.delete();
        m_held = '0; m_held_prev = '0; m_press = '0; m_pending = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("rst_row", 32'(rowOut), 32'(4'b1110));
        check("rst_held", 32'(held), 0);
        check("rst_press", 32'(press), 0);
        check("rst_valid", 32'(evValid), 0);
        check("rst_code", 32'(evCode), 0);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic tick();
        logic [N-1:0] rise, snap;
        int row;
        @(posedge Clock);
        n++;
        hist.push_back(keys);
        rise = m_held & ~m_held_prev;
        if (evAck && m_pending != '0) m_pending &= ~(m_pending & (~m_pending + 1'b1));
        m_pending  |= rise;
        m_press     = rise;
        m_held_prev = m_held;
        // held moves the edge after a row sample; that sample saw the pins of edge n-3
        if (n >= 5 && (n - 1) % DWELL == 0) begin
            row  = ((n - 2) / DWELL) % ROWS;
            snap = hist[n-4];
            for (int c = 0; c < COLS; c++) begin
                int k = row * COLS + c;
                if (snap[k] != m_held[k]) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == DEB_SCANS) begin
                        m_held[k] = ~m_held[k];
                        m_cnt[k]  = 0;
                    end
                end else begin
                    m_cnt[k] = 0;
                end
            end
        end
        #2;
        check("rowOut", 32'(rowOut), 32'(~(4'b0001 << ((n / DWELL) % ROWS)) & 4'hF));
        check("held", 32'(held), 32'(m_held));
        check("press", 32'(press), 32'(m_press));
        check("evValid", 32'(evValid), 32'(m_pending != '0));
        if (m_pending != '0) begin
            int low = 0;
            for (int i = N - 1; i >= 0; i--) if (m_pending[i]) low = i;
            check("evCode", 32'(evCode), 32'(low));
        end
    endtask

    task automatic ticks(input int cnt);
        for (int i = 0; i < cnt; i++) tick();
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < PERIOD && (n % PERIOD) != phase; i++) tick();
    endtask

    task automatic ack_once();
        evAck = 1'b1;
        tick();
        evAck = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // idle scan
        ticks(40);
        check("idle_held", 32'(held), 0);

        // single press of key 6, then ack
        keys[6] = 1'b1;
        ticks(4 * PERIOD);
        check("single_valid", 32'(evValid), 1);
        check("single_code", 32'(evCode), 6);
        ack_once();
        ticks(3);

        // release: no pulse, no event
        keys[6] = 1'b0;
        ticks(4 * PERIOD);
        check("release_held", 32'(held), 0);

        // bounce: key 6 alternates between row-1 samples
        align(0);
        for (int s = 0; s < 10; s++) begin
            keys[6] = ~keys[6];
            ticks(PERIOD);
        end
        keys[6] = 1'b0;
        check("bounce_held", 32'(held), 0);
        check("bounce_valid", 32'(evValid), 0);
        ticks(2 * PERIOD);

        // ordering of simultaneous presses
        keys[3] = 1'b1;
        keys[9] = 1'b1;
        ticks(4 * PERIOD);
        check("order_first", 32'(evCode), 3);
        ack_once();
        check("order_second", 32'(evCode), 9);
        ack_once();
        ack_once();
        ack_once();
        check("order_empty", 32'(evValid), 0);
        keys = '0;
        ticks(4 * PERIOD);

        // reset at d=2 of row 2 while key 6 is held and pending
        keys[6] = 1'b1;
        ticks(4 * PERIOD);
        align(2 * DWELL + 2);
        do_reset();
        ticks(4 * PERIOD);
        check("rst_redetect", 32'(held[6]), 1);
        check("rst_event", 32'(evCode), 6);

        // random keys and acks
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(47, 0) == 0) keys[$urandom_range(N - 1, 0)] ^= 1'b1;
            evAck = ($urandom_range(3, 0) == 0);
            tick();
        end
        evAck = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Row-scanning reader for an external key/pad matrix on GPIO. It is the input-side counterpart of the LED matrix row/column scan used for the game display. It drives one row low at a time, samples the active-low column lines, and debounces each key over whole scans. It produces held state, one-cycle press pulses, and a queued press-event stream that scoring/control logic consumes with a valid/ack handshake.

## Interface

Parameters:
- ROWS, 4: matrix rows; key count N = ROWS*COLS.
- COLS, 4: matrix columns.
- DWELL, 4: clocks each row stays driven; minimum 3.
- DEB_SCANS, 3: consecutive differing samples required to flip a key's debounced state; minimum 1.

Ports (clock and reset first):
- Clock, input, 1: single clock; all state on its rising edge.
- Reset, input, 1: asynchronous, active-high; clears all state.
- colIn, input, COLS: column lines, active-low (pulled up, pressed key pulls low); asynchronous to Clock.
- rowOut, output, ROWS: row drive, active-low one-hot.
- held, output, N: debounced key state; bit r*COLS+c = key at row r, column c.
- press, output, N: one-cycle pulse on each 0->1 of held.
- evValid, output, 1: at least one unacknowledged press event pending.
- evCode, output, clog2(N) (min 1): index of lowest pending key; valid only while evValid=1.
- evAck, input, 1: consumer accepts the event at evCode this cycle.

## Operation

- Synchronizer: colIn passes through a 2-flop synchronizer and is inverted, giving colSync (1 = pressed).
- Scan FSM: row index r (0..ROWS-1) and dwell counter d (0..DWELL-1).
  - rowOut = ~(1<<r).
  - d increments each clock. At d=DWELL-1, d wraps to 0 and r advances; r wraps ROWS-1 -> 0.
- Sample point: the cycle with d=DWELL-1. colSync is taken as raw[r*COLS +: COLS] for the current r. Its pin value dates from d=DWELL-3, so lines have settled ≥1 clock after the row switch.
- Debounce, per key, updated only at that key's row sample:
  - raw == held: the key's counter clears to 0.
  - raw != held: the counter increments. When it reaches DEB_SCANS, held flips and the counter clears.
- Press: press[k] is a registered pulse, high for exactly the one cycle after held[k] goes 0->1. Release (1->0) produces no pulse and no event.
- Event queue: a pending[N] register.
  - pending[k] sets on the same edge press[k] rises.
  - evValid = |pending.
  - evCode = index of lowest set bit of pending. Both are combinational from registers, so there is no extra latency.
  - evAck with evValid=1 clears pending[evCode] on that edge.
  - evAck with evValid=0 is ignored.
- Simultaneous events:
  - A set and an ack-clear of the same bit in one cycle: set wins; the bit stays pending.
  - Several keys flipping in the same row sample all set held, press and pending together.
  - A re-press of an already pending key re-sets its bit. There is no counting; one event results.

## Timing

- Reset values:
  - rowOut = all ones except bit 0 low (4'b1110 by default).
  - r = 0, d = 0.
  - held, press, pending, raw, synchronizer flops and debounce counters = 0.
  - evValid = 0, evCode = 0.
- Scan period = ROWS*DWELL clocks (16 by default). Row 0 is sampled at the 4th clock after reset deasserts.
- Press latency from a stable pin to held: between (DEB_SCANS-1)*period + 3 and DEB_SCANS*period + 3 clocks. The press pulse and pending set follow one clock after held.
- Reset asserted mid-scan: all outputs return to reset values immediately. Pending events and partial debounce counts are lost, and the scan restarts at row 0.
- A key held through reset is re-detected as a new press after DEB_SCANS scans.

## Test plan

Default parameters; the bench models the matrix by pulling colIn[c] low when rowOut[r]=0 and key (r,c) is closed.

- Reset/scan: pulse Reset, then run 40 clocks with no keys -> rowOut is 1110 for 4 clocks, then 1101, 1011, 0111 for 4 each, then wraps to 1110. held, press and evValid stay 0.
- Single press: close key 6 (row1,col2) -> held[6]=1 after the 3rd row-1 sample; press[6] high exactly 1 cycle; evValid=1 with evCode=6 until a 1-cycle evAck, then evValid=0 the next cycle.
- Bounce: key 6 closed on alternate row-1 samples for 10 scans -> held[6] stays 0, no press, evValid stays 0.
- Ordering: close keys 3 and 9 together -> evCode=3 first. Ack -> evCode=9. Ack -> evValid=0. Ack issued while evValid=0 has no effect.
- Release: after key 6 is held, open it -> held[6]=0 after 3 scans; no press pulse, no event.
- Reset mid-operation: key 6 held and pending, assert Reset at d=2 of row 2 -> rowOut=1110, held=0, evValid=0 at once. With the key still closed after release, held[6] returns after 3 scans with a new event.
